// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and helpers for the fault-tolerance voter slice.
//  ft_mode_e      : redundancy mode. It doubles as the voter FSM state encoding.
//  onehot_lowest  : returns a one-hot vector of the lowest set bit of a 3-bit vector.
//                   It returns 000 when no bit is set.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        TMR  = 2'b00,
        DMR  = 2'b01,
        FAIL = 2'b10
    } ft_mode_e;

    function automatic logic [2:0] onehot_lowest(logic [2:0] v);
        if (v[0]) return 3'b001;
        if (v[1]) return 3'b010;
        if (v[2]) return 3'b100;
        return 3'b000;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_health_voter_if.sv
// Bundle of the voter's data and status signals.
//  Inputs to the voter : valid_i, in_1_i, in_2_i, in_3_i, clear_i
//  Outputs of the voter: voted_o, err_detected_o, err_corrected_o,
//                        broken_o, mode_o, fatal_o, retire_evt_o
// Handshake: valid_i is a pure qualifier with no ready. The replicas are sampled
// on every clk edge where valid_i=1. The voter can never stall its producer.
// master = the replica producer / FT controller; slave = the voter.
interface cv32e40p_tmr_health_voter_if #(
    parameter int L1 = 32,
    parameter int L2 = 1
);
    logic                    valid_i;
    logic [L1-1:0][L2-1:0]   in_1_i;
    logic [L1-1:0][L2-1:0]   in_2_i;
    logic [L1-1:0][L2-1:0]   in_3_i;
    logic                    clear_i;
    logic [L1-1:0][L2-1:0]   voted_o;
    logic [2:0]              err_detected_o;
    logic                    err_corrected_o;
    logic [2:0]              broken_o;
    logic [1:0]              mode_o;
    logic                    fatal_o;
    logic                    retire_evt_o;

    modport master (
        output valid_i, in_1_i, in_2_i, in_3_i, clear_i,
        input  voted_o, err_detected_o, err_corrected_o,
               broken_o, mode_o, fatal_o, retire_evt_o
    );

    modport slave (
        input  valid_i, in_1_i, in_2_i, in_3_i, clear_i,
        output voted_o, err_detected_o, err_corrected_o,
               broken_o, mode_o, fatal_o, retire_evt_o
    );
endinterface

// File: rtl/cv32e40p_3voter.sv
// Combinational 3-replica word voter with a broken-replica mask.
//  in_1_i..in_3_i   : replicas
//  broken_i         : one-hot retired replica. 000 means a full 2-of-3 vote.
//  voted_o          : selected / majority data
//  err_detected_N_o : replica N disagrees (not qualified by valid)
//  err_corrected_o  : exactly one dissenter was out-voted
module cv32e40p_3voter #(
    parameter int L1 = 32,
    parameter int L2 = 1
) (
    input  logic [L1-1:0][L2-1:0] in_1_i,
    input  logic [L1-1:0][L2-1:0] in_2_i,
    input  logic [L1-1:0][L2-1:0] in_3_i,
    input  logic [2:0]            broken_i,
    output logic [L1-1:0][L2-1:0] voted_o,
    output logic                  err_detected_1_o,
    output logic                  err_detected_2_o,
    output logic                  err_detected_3_o,
    output logic                  err_corrected_o
);
    logic eq_12, eq_13, eq_23;

    assign eq_12 = (in_1_i == in_2_i);
    assign eq_13 = (in_1_i == in_3_i);
    assign eq_23 = (in_2_i == in_3_i);

    always_comb begin
        voted_o          = in_1_i;
        err_detected_1_o = 1'b0;
        err_detected_2_o = 1'b0;
        err_detected_3_o = 1'b0;
        err_corrected_o  = 1'b0;
        unique case (broken_i)
            3'b000: begin
                // Word-level majority. With no agreement, replica 1 is passed through.
                if (eq_12 && eq_13) begin
                    voted_o = in_1_i;
                end else if (eq_12) begin
                    err_detected_3_o = 1'b1;
                    err_corrected_o  = 1'b1;
                end else if (eq_13) begin
                    err_detected_2_o = 1'b1;
                    err_corrected_o  = 1'b1;
                end else if (eq_23) begin
                    voted_o          = in_2_i;
                    err_detected_1_o = 1'b1;
                    err_corrected_o  = 1'b1;
                end else begin
                    err_detected_1_o = 1'b1;
                    err_detected_2_o = 1'b1;
                    err_detected_3_o = 1'b1;
                end
            end
            3'b001: begin
                voted_o          = in_2_i;
                err_detected_2_o = !eq_23;
                err_detected_3_o = !eq_23;
            end
            3'b010: begin
                err_detected_1_o = !eq_13;
                err_detected_3_o = !eq_13;
            end
            3'b100: begin
                err_detected_1_o = !eq_12;
                err_detected_2_o = !eq_12;
            end
            default: begin
                voted_o = in_1_i;
            end
        endcase
    end
endmodule

// File: rtl/cv32e40p_tmr_health_voter.sv
// Stateful 2-of-3 voter. It degrades TMR -> DMR -> FAIL as replicas keep disagreeing.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave side of cv32e40p_tmr_health_voter_if (see that file for signals)
// A per-replica counter counts consecutive flagged valid cycles. A replica is
// retired when its counter reaches THRESHOLD. The FSM state is exported directly on mode_o.
module cv32e40p_tmr_health_voter
    import cv32e40p_ft_pkg::*;
#(
    parameter int L1        = 32,
    parameter int L2        = 1,
    parameter int THRESHOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cv32e40p_tmr_health_voter_if.slave   bus
);
    localparam int              CNT_W   = $clog2(THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(THRESHOLD - 1);

    ft_mode_e         state_q, state_d;
    logic [2:0]       broken_q, broken_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       flags;
    logic [2:0]       hit;
    logic             e1, e2, e3, corr_raw;

    cv32e40p_3voter #(.L1(L1), .L2(L2)) u_voter (
        .in_1_i           (bus.in_1_i),
        .in_2_i           (bus.in_2_i),
        .in_3_i           (bus.in_3_i),
        .broken_i         (broken_q),
        .voted_o          (bus.voted_o),
        .err_detected_1_o (e1),
        .err_detected_2_o (e2),
        .err_detected_3_o (e3),
        .err_corrected_o  (corr_raw)
    );

    assign flags               = bus.valid_i ? {e3, e2, e1} : 3'b000;
    assign bus.err_detected_o  = flags;
    assign bus.err_corrected_o = bus.valid_i & corr_raw;

    // A replica reaches the threshold on this edge.
    always_comb begin
        hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            hit[i] = flags[i] && !broken_q[i] && (cnt_q[i] == CNT_PRE);
        end
    end

    // Consecutive-error counters. A retired replica's counter stays frozen at THRESHOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (bus.valid_i) begin
            for (int i = 0; i < 3; i++) begin
                if (!broken_q[i]) begin
                    if (!flags[i])               cnt_q[i] <= '0;
                    else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // FSM state register, which also holds the registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TMR;
            broken_q <= 3'b000;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            broken_q <= broken_d;
            retire_q <= retire_d;
        end
    end

    // Next-state logic. clear_i overrides any retire or fail event in the same cycle.
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = TMR;
        end else if (bus.valid_i) begin
            case (state_q)
                TMR: begin
                    if ($countones(hit) == 1)     state_d = DMR;
                    else if ($countones(hit) > 1) state_d = FAIL;
                end
                DMR:     if (flags != 3'b000) state_d = FAIL;
                FAIL:    state_d = FAIL;
                default: state_d = state_q;
            endcase
        end
    end

    // Output logic for the registered status.
    always_comb begin
        broken_d = broken_q;
        retire_d = 1'b0;
        if (bus.clear_i) begin
            broken_d = 3'b000;
        end else if (state_q == TMR && hit != 3'b000) begin
            broken_d = onehot_lowest(hit);
            retire_d = 1'b1;
        end
    end

    assign bus.broken_o     = broken_q;
    assign bus.mode_o       = state_q;
    assign bus.fatal_o      = (state_q == FAIL);
    assign bus.retire_evt_o = retire_q;
endmodule

// File: tb/tb_cv32e40p_tmr_health_voter.sv
module tb_cv32e40p_tmr_health_voter;
    import cv32e40p_ft_pkg::*;

    localparam int L1  = 32;
    localparam int L2  = 1;
    localparam int THR = 4;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40p_tmr_health_voter_if #(.L1(L1), .L2(L2)) bus  ();
    cv32e40p_tmr_health_voter_if #(.L1(L1), .L2(L2)) bus1 ();

    // Second instance with THRESHOLD=1 shares the stimulus.
    assign bus1.valid_i = bus.valid_i;
    assign bus1.in_1_i  = bus.in_1_i;
    assign bus1.in_2_i  = bus.in_2_i;
    assign bus1.in_3_i  = bus.in_3_i;
    assign bus1.clear_i = bus.clear_i;

    cv32e40p_tmr_health_voter #(.L1(L1), .L2(L2), .THRESHOLD(THR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cv32e40p_tmr_health_voter #(.L1(L1), .L2(L2), .THRESHOLD(1)) dut_t1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // scoreboard
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // reference model state
    int          m_mode;
    logic [2:0]  m_broken;
    int          m_cnt [3];
    logic        m_retire;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_broken = 3'b000;
        m_retire = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic model_comb(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, output logic [31:0] vo,
                              output logic [2:0] det, output logic corr);
        logic [31:0] r [3];
        int lo, hi;
        r[0] = a; r[1] = b; r[2] = c;
        det  = 3'b000;
        corr = 1'b0;
        vo   = a;
        if (m_broken == 3'b000) begin
            if (a == b && b == c) vo = a;
            else if (a == b) begin vo = a; det = 3'b100; corr = 1'b1; end
            else if (a == c) begin vo = a; det = 3'b010; corr = 1'b1; end
            else if (b == c) begin vo = b; det = 3'b001; corr = 1'b1; end
            else det = 3'b111;
        end else begin
            lo = m_broken[0] ? 1 : 0;
            hi = m_broken[2] ? 1 : 2;
            vo = r[lo];
            if (r[lo] != r[hi]) begin
                det[lo] = 1'b1;
                det[hi] = 1'b1;
            end
        end
        if (!v) begin
            det  = 3'b000;
            corr = 1'b0;
        end
    endtask

    task automatic model_seq(input logic v, input logic clr, input logic [2:0] det);
        logic [2:0] hits;
        int nh;
        m_retire = 1'b0;
        if (clr) begin
            m_mode   = 0;
            m_broken = 3'b000;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else if (v) begin
            hits = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (!m_broken[i]) begin
                    if (det[i]) begin
                        if (m_cnt[i] == THR - 1) hits[i] = 1'b1;
                        if (m_cnt[i] < THR) m_cnt[i]++;
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end
            nh = $countones(hits);
            if (m_mode == 0 && nh > 0) begin
                m_retire = 1'b1;
                m_broken = hits[0] ? 3'b001 : (hits[1] ? 3'b010 : 3'b100);
                m_mode   = (nh == 1) ? 1 : 2;
            end else if (m_mode == 1 && det != 3'b000) begin
                m_mode = 2;
            end
        end
    endtask

    // driver: one clock cycle of stimulus, with combinational and registered checks
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic clr);
        logic [31:0] ev;
        logic [2:0]  ed;
        logic        ec;
        logic [63:0] e;
        @(negedge clk);
        bus.valid_i = v;
        bus.in_1_i  = a;
        bus.in_2_i  = b;
        bus.in_3_i  = c;
        bus.clear_i = clr;
        model_comb(v, a, b, c, ev, ed, ec);
        exp_q.push_back({28'd0, ev, ed, ec});
        #1;
        e = exp_q.pop_front();
        check("voted", 64'(bus.voted_o), 64'(e[35:4]));
        check("err_detected", 64'(bus.err_detected_o), 64'(e[3:1]));
        check("err_corrected", 64'(bus.err_corrected_o), 64'(e[0]));
        model_seq(v, clr, ed);
        exp_q.push_back({57'd0, m_broken, 2'(m_mode), (m_mode == 2), m_retire});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("broken", 64'(bus.broken_o), 64'(e[6:4]));
        check("mode", 64'(bus.mode_o), 64'(e[3:2]));
        check("fatal", 64'(bus.fatal_o), 64'(e[1]));
        check("retire_evt", 64'(bus.retire_evt_o), 64'(e[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_broken"}, 64'(bus.broken_o), 64'(3'b000));
        check({tag, "_mode"}, 64'(bus.mode_o), 64'(TMR));
        check({tag, "_fatal"}, 64'(bus.fatal_o), 64'(1'b0));
        check({tag, "_retire"}, 64'(bus.retire_evt_o), 64'(1'b0));
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.in_1_i  = '0;
        bus.in_2_i  = '0;
        bus.in_3_i  = '0;
        bus.clear_i = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // all replicas agree
        repeat (10) step(1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);

        // replica 2 dissents; the THRESHOLD=1 instance retires it on the first cycle
        step(1'b1, 32'h0, 32'h1, 32'h0, 1'b0);
        check("t1_mode", 64'(bus1.mode_o), 64'(DMR));
        check("t1_broken", 64'(bus1.broken_o), 64'(3'b010));
        check("t1_retire", 64'(bus1.retire_evt_o), 64'(1'b1));
        repeat (3) step(1'b1, 32'h0, 32'h1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 32'h1, 32'h0, 1'b0);   // retire pulse drops

        // healthy pair disagrees in DMR: FAIL, sticky with valid low
        step(1'b1, 32'h5, 32'h9, 32'h6, 1'b0);
        repeat (3) step(1'b0, 32'h5, 32'h9, 32'h6, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // replica 3: 3 flagged, 1 clean, 3 flagged -> stays TMR
        repeat (3) step(1'b1, 32'h0, 32'h0, 32'h8, 1'b0);
        step(1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 32'h0, 32'h0, 32'h8, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // all three differ -> TMR to FAIL with broken 001
        repeat (4) step(1'b1, 32'h1, 32'h2, 32'h3, 1'b0);
        step(1'b1, 32'h1, 32'h2, 32'h3, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // clear collides with a pending retire
        repeat (3) step(1'b1, 32'hF, 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'hF, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'hF, 32'h0, 32'h0, 1'b0);   // counter restarted from zero

        // random traffic
        for (int k = 0; k < 60; k++) begin
            step(1'b1 & ($urandom_range(0, 3) != 0),
                 32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)),
                 32'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
        end

        // reach DMR, then assert reset mid-cycle
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 32'h0, 32'h4, 32'h0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.in_1_i  = 32'h7;
        bus.in_2_i  = 32'h9;
        bus.in_3_i  = 32'h9;
        bus.clear_i = 1'b0;
        #1;
        check("dmr_voted_pre_rst", 64'(bus.voted_o), 64'(32'h7));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        check("rst_voted", 64'(bus.voted_o), 64'(32'h9));
        check("rst_err_detected", 64'(bus.err_detected_o), 64'(3'b001));
        model_reset();
        @(negedge clk);
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 32'h3, 32'h3, 32'h3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
